udp_video_rx: RTL

UDP_VIDEO_RX -- requirements
Module: udp_video_rx

---
 rtl/udp_video_rx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/udp_video_rx.sv
// udp_video_rx: GMII UDP line-packet receiver -> line header, {Y,C} pixel strobes, frame status (CRC check: UDP_VIDEO_RX_CRC_CHECK_EN).
// Latency: line_start/pix_we/frame_done are registered, one cycle after the deciding byte is sampled.
// Backpressure: none; GMII is a push stream and every output is a single-cycle strobe.
module udp_video_rx #(
  parameter logic [47:0] dst_mac     = 48'h002345678902,
  parameter logic [31:0] ip_dst_addr = {8'd192, 8'd168, 8'd0, 8'd2},
  parameter logic [15:0] udp_port    = 16'h3039,
  parameter logic [10:0] pix_bytes   = 11'd1280
) (
  input  logic        rx_clk,
  input  logic        sys_rst_n,
  input  logic        id,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        line_start,
  output logic [15:0] line_hdr,
  output logic        pix_we,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] err_cnt
);

  typedef enum logic [3:0] {IDLE, PRE, ETH, IP, UDP, HDR, PAY, FCS, TAIL, DROP} state_t;

  state_t      st, nxt;
  logic [10:0] cnt;
  logic        armed, err_r;
  logic [7:0]  byte_hold;
  logic [47:0] mac_exp;
  logic [31:0] ip_exp;
  logic [7:0]  mac_byte, ip_byte;
  logic        eth_bad, ip_bad, udp_bad, crc_ok;
  logic        in_frame, err_now, hdr_hi_cap, hdr_lo_cap, y_cap, pix_fire, done_fire, done_ok;

  assign mac_exp  = dst_mac - {47'd0, id};
  assign ip_exp   = {ip_dst_addr[31:8], ip_dst_addr[7:0] - {7'd0, id}};
  assign mac_byte = 8'(mac_exp >> {3'd5 - cnt[2:0], 3'b000});
  assign ip_byte  = 8'(ip_exp >> {2'd3 - cnt[1:0], 3'b000});

  assign eth_bad = (cnt < 11'd6 && rxd != mac_byte) || (cnt == 11'd12 && rxd != 8'h08) ||
                   (cnt == 11'd13 && rxd != 8'h00);
  assign ip_bad  = (cnt == 11'd0 && rxd != 8'h45) || (cnt == 11'd9 && rxd != 8'h11) ||
                   (cnt >= 11'd16 && rxd != ip_byte);
  assign udp_bad = (cnt == 11'd2 && rxd != udp_port[15:8]) || (cnt == 11'd3 && rxd != udp_port[7:0]);

  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      st  <= nxt;
      cnt <= (nxt != st) ? 11'd0 : cnt + 11'd1;
    end
  end

  always_comb begin
    nxt = st;
    case (st)
      IDLE: if (rx_dv) nxt = (armed && !rx_er && rxd == 8'h55) ? PRE : DROP;
      PRE:  if (!rx_dv || rx_er)               nxt = DROP;
            else if (rxd == 8'hD5)             nxt = ETH;
            else if (rxd != 8'h55)             nxt = DROP;
      ETH:  if (!rx_dv || rx_er || eth_bad)    nxt = DROP;
            else if (cnt == 11'd13)            nxt = IP;
      IP:   if (!rx_dv || rx_er || ip_bad)     nxt = DROP;
            else if (cnt == 11'd19)            nxt = UDP;
      UDP:  if (!rx_dv || rx_er || udp_bad)    nxt = DROP;
            else if (cnt == 11'd7)             nxt = HDR;
      HDR:  if (!rx_dv)                        nxt = IDLE;
            else if (cnt == 11'd1)             nxt = PAY;
      PAY:  if (!rx_dv)                        nxt = IDLE;
            else if (cnt == pix_bytes - 11'd1) nxt = FCS;
      FCS:  if (!rx_dv)                        nxt = IDLE;
            else if (cnt == 11'd3)             nxt = TAIL;
      TAIL: if (!rx_dv)                        nxt = IDLE;
      DROP: if (!rx_dv)                        nxt = IDLE;
      default:                                 nxt = IDLE;
    endcase
  end

  // Once past UDP the frame is committed: errors are latched and reported at frame end.
  always_comb begin
    in_frame   = st inside {HDR, PAY, FCS, TAIL};
    err_now    = err_r || (rx_dv && (rx_er || st == TAIL));
    hdr_hi_cap = st == HDR && rx_dv && cnt == 11'd0;
    hdr_lo_cap = st == HDR && rx_dv && cnt == 11'd1;
    y_cap      = st == PAY && rx_dv && !cnt[0];
    pix_fire   = st == PAY && rx_dv && cnt[0] && !err_now;
    done_fire  = in_frame && !rx_dv;
    done_ok    = st == TAIL && !err_r && crc_ok;
  end

  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      armed      <= 1'b0;
      err_r      <= 1'b0;
      byte_hold  <= '0;
      line_start <= 1'b0;
      line_hdr   <= '0;
      pix_we     <= 1'b0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      armed      <= armed || !rx_dv;
      err_r      <= in_frame && err_now;
      line_start <= hdr_lo_cap;
      pix_we     <= pix_fire;
      frame_done <= done_fire;
      frame_ok   <= done_fire && done_ok;
      if (hdr_hi_cap || y_cap) byte_hold <= rxd;
      if (hdr_lo_cap)          line_hdr  <= {byte_hold, rxd};
      if (pix_fire)            pix_data  <= {byte_hold, rxd};
      if (done_fire && !done_ok && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

`ifdef UDP_VIDEO_RX_CRC_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                        crc <= '1;
    else if (st == PRE)                                    crc <= '1;
    else if (rx_dv && st inside {ETH, IP, UDP, HDR, PAY, FCS}) crc <= crc_byte(crc, rxd);
  end

  // LSB-first register; the residue constant is stated MSB-first.
  assign crc_ok = ({<<{crc}} == 32'hC704DD7B);
`else
  assign crc_ok = 1'b1;
`endif

endmodule
